// File: rtl/lalu_mem_arbiter.sv
// lalu_mem_arbiter: shares the LALU single-port memory between instruction
// fetch (IF) and load/store (LS). One transaction in flight at a time; the
// response returns MEM_LAT+1 cycles after the issue cycle.
// Build option LALU_ARB_RR_EN: strict alternation when both ports request.
// When it is undefined, LS has priority and IF is forced to win after
// STARVE_MAX consecutive losses.
module lalu_mem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win_ls_q, win_ls_d;
    logic          we_q, we_d;
    logic          arb_ls_c;
    logic          any_req_c;

    logic          if_gnt_d, if_rvalid_d, ls_gnt_d, ls_rvalid_d;
    logic [DW-1:0] if_rdata_d, ls_rdata_d;
    logic          mem_en_d, mem_we_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;

`ifdef LALU_ARB_RR_EN
    logic          last_ls_q, last_ls_d;
`else
    logic [SW-1:0] starve_q, starve_d;
    logic [SW-1:0] starve_arb_c;
`endif

    assign any_req_c = if_req | ls_req;

    // Winner selection, evaluated whenever the FSM may enter ISSUE
`ifdef LALU_ARB_RR_EN
    always_comb begin
        arb_ls_c = ls_req & (~if_req | ~last_ls_q);
    end
`else
    always_comb begin
        arb_ls_c     = ls_req & (~if_req | (starve_q != SW'(STARVE_MAX)));
        starve_arb_c = '0;
        if (if_req && arb_ls_c) begin
            starve_arb_c = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
        end
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        logic do_arb;
        do_arb      = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_ls_d    = win_ls_q;
        we_d        = we_q;
        if_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ls_gnt_d    = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata;
        ls_rdata_d  = ls_rdata;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
`ifdef LALU_ARB_RR_EN
        last_ls_d   = last_ls_q;
`else
        starve_d    = starve_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (any_req_c) begin
                    state_d = S_ISSUE;
                    do_arb  = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (cnt_q == CW'(MEM_LAT - 1)) begin
                    state_d = S_RESP;
                    if (win_ls_q) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = we_q ? '0 : mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (any_req_c) begin
                    state_d = S_ISSUE;
                    do_arb  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Latch the winner's request onto the memory port for the ISSUE cycle
        if (do_arb) begin
            win_ls_d    = arb_ls_c;
            we_d        = arb_ls_c & ls_we;
            mem_en_d    = 1'b1;
            mem_we_d    = arb_ls_c & ls_we;
            mem_addr_d  = arb_ls_c ? ls_addr : if_addr;
            mem_wdata_d = arb_ls_c ? ls_wdata : '0;
            if_gnt_d    = ~arb_ls_c;
            ls_gnt_d    = arb_ls_c;
`ifdef LALU_ARB_RR_EN
            last_ls_d   = arb_ls_c;
`else
            starve_d    = starve_arb_c;
`endif
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            win_ls_q  <= 1'b0;
            we_q      <= 1'b0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_gnt    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef LALU_ARB_RR_EN
            last_ls_q <= 1'b0;
`else
            starve_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_ls_q  <= win_ls_d;
            we_q      <= we_d;
            if_gnt    <= if_gnt_d;
            if_rvalid <= if_rvalid_d;
            if_rdata  <= if_rdata_d;
            ls_gnt    <= ls_gnt_d;
            ls_rvalid <= ls_rvalid_d;
            ls_rdata  <= ls_rdata_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
`ifdef LALU_ARB_RR_EN
            last_ls_q <= last_ls_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

endmodule

// File: tb/tb_lalu_mem_arbiter.sv
// Directed bench for lalu_mem_arbiter with MEM_LAT=2, STARVE_MAX=3.
module tb_lalu_mem_arbiter;

    localparam int unsigned AW         = 32;
    localparam int unsigned DW         = 32;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lalu_mem_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents: one marked word, everything else derived from the address
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    // Two-stage read pipeline: data valid two cycles after mem_en
    logic [DW-1:0] p1 = '0;
    logic [DW-1:0] p2 = '0;
    always @(posedge clk) begin
        p1 <= mem_en ? mem_model(mem_addr) : '0;
        p2 <= p1;
    end
    assign mem_rdata = p2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        return |{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                 mem_en, mem_we, mem_addr, mem_wdata};
    endfunction

    initial begin
        logic [7:0] seq;
        logic [7:0] seq_exp;
        int         ng;

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        tick(); tick();
        chk("reset_outputs", 64'(any_out()), 64'd0);
        rst = 1'b0;
        tick();

        // IF read of 0x10
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("t1_mem_en",   64'(mem_en),   64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h10);
        chk("t1_if_gnt",   64'(if_gnt),   64'd1);
        chk("t1_ls_gnt",   64'(ls_gnt),   64'd0);
        chk("t1_mem_we",   64'(mem_we),   64'd0);
        if_req = 1'b0;
        tick();
        chk("t1_c2_rvalid", 64'(if_rvalid), 64'd0);
        chk("t1_c2_mem_en", 64'(mem_en),    64'd0);
        tick();
        chk("t1_c3_rvalid", 64'(if_rvalid), 64'd0);
        tick();
        chk("t1_c4_rvalid", 64'(if_rvalid), 64'd1);
        chk("t1_c4_rdata",  64'(if_rdata),  64'hDEADBEEF);
        chk("t1_c4_ls_rv",  64'(ls_rvalid), 64'd0);
        tick();
        chk("t1_c5_rvalid", 64'(if_rvalid), 64'd0);
        chk("t1_c5_hold",   64'(if_rdata),  64'hDEADBEEF);

        // Both request together: LS first, IF right behind it
        if_req = 1'b1; if_addr = 32'h40;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
        tick();
        chk("t2_c1_ls_gnt", 64'(ls_gnt),   64'd1);
        chk("t2_c1_if_gnt", 64'(if_gnt),   64'd0);
        chk("t2_c1_addr",   64'(mem_addr), 64'h80);
        ls_req = 1'b0;
        tick(); tick(); tick();
        chk("t2_c4_ls_rv",  64'(ls_rvalid), 64'd1);
        chk("t2_c4_ls_rd",  64'(ls_rdata),  64'hA5A5_0080);
        chk("t2_c4_if_rv",  64'(if_rvalid), 64'd0);
        tick();
        chk("t2_c5_if_gnt", 64'(if_gnt),   64'd1);
        chk("t2_c5_ls_gnt", 64'(ls_gnt),   64'd0);
        chk("t2_c5_addr",   64'(mem_addr), 64'h40);
        if_req = 1'b0;
        tick(); tick(); tick();
        chk("t2_c8_if_rv",  64'(if_rvalid), 64'd1);
        chk("t2_c8_if_rd",  64'(if_rdata),  64'hA5A5_0040);
        tick();

        // LS write
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h55;
        tick();
        chk("t4_c1_ls_gnt", 64'(ls_gnt),    64'd1);
        chk("t4_c1_we",     64'(mem_we),    64'd1);
        chk("t4_c1_wdata",  64'(mem_wdata), 64'h55);
        chk("t4_c1_addr",   64'(mem_addr),  64'h20);
        ls_req = 1'b0; ls_we = 1'b0;
        tick(); tick(); tick();
        chk("t4_c4_ls_rv",  64'(ls_rvalid), 64'd1);
        chk("t4_c4_ls_rd",  64'(ls_rdata),  64'd0);
        chk("t4_if_hold",   64'(if_rdata),  64'hA5A5_0040);
        tick();

        // Reset in the middle of an IF read
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("t5_c1_if_gnt", 64'(if_gnt), 64'd1);
        if_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t5_async_rst", 64'(any_out()), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_resp", 64'(any_out()), 64'd0);
        end
        if_req = 1'b1; if_addr = 32'h30;
        tick();
        chk("t5_re_gnt",  64'(if_gnt),   64'd1);
        chk("t5_re_addr", 64'(mem_addr), 64'h30);
        if_req = 1'b0;
        tick(); tick();
        chk("t5_re_c3_rv", 64'(if_rvalid), 64'd0);
        tick();
        chk("t5_re_rv", 64'(if_rvalid), 64'd1);
        chk("t5_re_rd", 64'(if_rdata),  64'hA5A5_0030);
        tick();

        // Both held high: grant pattern over eight transactions
`ifdef LALU_ARB_RR_EN
        seq_exp = 8'h55;
`else
        seq_exp = 8'h77;
`endif
        seq = '0;
        ng  = 0;
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
        for (int c = 1; c <= 32; c++) begin
            tick();
            chk("t3_dual_gnt", 64'(if_gnt & ls_gnt), 64'd0);
            chk("t3_gnt_slot", 64'(if_gnt | ls_gnt), 64'((c % 4) == 1));
            if (if_gnt || ls_gnt) begin
                if (ng < 8) seq[3'(ng)] = ls_gnt;
                ng++;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("t3_gnt_count", 64'(ng),  64'd8);
        chk("t3_gnt_order", 64'(seq), 64'(seq_exp));
        tick(); tick();
        chk("t3_idle", 64'(if_gnt | ls_gnt | mem_en), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
